// File: rtl/rps_match_controller.sv
// rps_match_controller
//   Match sequencer for a first-to-WINS_TO_MATCH rock-paper-scissors game.
//   Synchronizes and edge-detects the choice buttons, requests one round per
//   press from the single-round judge (round_start/round_done handshake),
//   tallies the returned results, holds each result on the LEDs for
//   HOLD_CYCLES cycles and announces the match winner with a blinking code.
//
//   Optional build macro: RPS_ROUND_TIMEOUT_EN
//     defined   -> a round with no round_done within TIMEOUT_CYCLES is scored
//                  as a tie and flags protocol_err.
//     undefined -> REQUEST waits for round_done indefinitely.
//
// Ports
//   CLK, RST_N       clock, asynchronous active-low reset
//   btn_choice[2:0]  raw buttons (bit0 rock, bit1 paper, bit2 scissors)
//   new_match        raw button, starts a new match once one is decided
//   round_start      round request to the judge (held until round_done)
//   round_choice     person choice: 1 rock, 2 paper, 3 scissors
//   round_done       judge completion strobe
//   round_result     one-hot judge result: 1 person, 2 computer, 4 tie
//   display[2:0]     LED pattern {LED1,LED2,LED3}
//   person_score     person round wins
//   computer_score   computer round wins
//   match_over       high while the match is decided
//   match_winner     0 none, 1 person, 2 computer
//   protocol_err     sticky: stray round_done, bad result or timeout
module rps_match_controller #(
  parameter int WINS_TO_MATCH = 3,
  parameter int HOLD_CYCLES   = 12000000
`ifdef RPS_ROUND_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [2:0] btn_choice,
  input  logic       new_match,
  output logic       round_start,
  output logic [1:0] round_choice,
  input  logic       round_done,
  input  logic [2:0] round_result,
  output logic [2:0] display,
  output logic [3:0] person_score,
  output logic [3:0] computer_score,
  output logic       match_over,
  output logic [1:0] match_winner,
  output logic       protocol_err
);

  localparam int         HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [3:0] WIN4   = 4'(WINS_TO_MATCH);

  typedef enum logic [2:0] {
    ST_ARMED, ST_REQUEST, ST_SHOW, ST_CHECK, ST_RELEASE, ST_MATCH_OVER
  } state_t;

  state_t state, state_d;

  logic [2:0]        btn_s1, btn_s2;
  logic              btn_any_q, press_q;
  logic [1:0]        btn_enc, press_choice_q;
  logic              nm_s1, nm_s2, nm_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic              blink_q;
  logic [2:0]        result_q;

  wire btn_any   = |btn_s2;
  wire btn_rise  = btn_any & ~btn_any_q;
  wire nm_rise   = nm_s2 & ~nm_q;
  wire hold_done = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));

`ifdef RPS_ROUND_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
  // A round_done in the same cycle as the limit still wins over the timeout.
  wire timeout_hit = (state == ST_REQUEST) && !round_done &&
                     (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                                            to_cnt <= '0;
    else if (state == ST_REQUEST && state_d == ST_REQUEST) to_cnt <= to_cnt + 1'b1;
    else                                                   to_cnt <= '0;
  end
`else
  wire timeout_hit = 1'b0;
`endif

  // Lowest index wins when several buttons are down together.
  always_comb begin
    btn_enc = 2'd0;
    if      (btn_s2[0]) btn_enc = 2'd1;
    else if (btn_s2[1]) btn_enc = 2'd2;
    else if (btn_s2[2]) btn_enc = 2'd3;
  end

  // The press is registered once more so press-to-round_start is 4 cycles.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of the others, exactly as the hardware does.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      btn_s1 <= '0; btn_s2 <= '0; btn_any_q <= 1'b0;
      press_q <= 1'b0; press_choice_q <= '0;
      nm_s1 <= 1'b0; nm_s2 <= 1'b0; nm_q <= 1'b0;
    end else begin
      btn_s1    <= btn_choice;
      btn_s2    <= btn_s1;
      btn_any_q <= btn_any;
      press_q   <= btn_rise;
      if (btn_rise) press_choice_q <= btn_enc;
      nm_s1 <= new_match;
      nm_s2 <= nm_s1;
      nm_q  <= nm_s2;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_ARMED;
    else        state <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state;
    unique case (state)
      ST_ARMED:      if (press_q) state_d = ST_REQUEST;
      ST_REQUEST:    if (round_done || timeout_hit) state_d = ST_SHOW;
      ST_SHOW:       if (hold_done) state_d = ST_CHECK;
      ST_CHECK:      state_d = (person_score == WIN4 || computer_score == WIN4)
                               ? ST_MATCH_OVER : ST_RELEASE;
      ST_RELEASE:    if (!btn_any) state_d = ST_ARMED;
      ST_MATCH_OVER: if (nm_rise) state_d = ST_RELEASE;
      default:       state_d = ST_ARMED;
    endcase
  end

  always_comb begin
    display = 3'b111;
    case (state)
      ST_SHOW:       display = result_q;
      ST_MATCH_OVER: display = blink_q ? 3'b000 : {1'b0, match_winner};
      default:       display = 3'b111;
    endcase
  end

  // Hold timer: restarts on every state change; in MATCH_OVER it wraps and
  // paces the winner blink.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_cnt <= '0;
      blink_q  <= 1'b0;
    end else begin
      if (state != state_d)
        hold_cnt <= '0;
      else if (state == ST_SHOW || state == ST_MATCH_OVER)
        hold_cnt <= hold_done ? '0 : hold_cnt + 1'b1;

      if (state_d == ST_MATCH_OVER && state != ST_MATCH_OVER)
        blink_q <= 1'b0;
      else if (state == ST_MATCH_OVER && hold_done)
        blink_q <= ~blink_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      round_start    <= 1'b0;
      round_choice   <= '0;
      result_q       <= '0;
      person_score   <= '0;
      computer_score <= '0;
      match_over     <= 1'b0;
      match_winner   <= '0;
      protocol_err   <= 1'b0;
    end else begin
      round_start <= (state_d == ST_REQUEST);
      if (state == ST_ARMED && press_q) round_choice <= press_choice_q;

      if (round_done && state != ST_REQUEST) protocol_err <= 1'b1;

      if (state == ST_REQUEST && round_done) begin
        result_q <= round_result;
        case (round_result)
          3'b001:  if (person_score < WIN4) person_score <= person_score + 4'd1;
          3'b010:  if (computer_score < WIN4) computer_score <= computer_score + 4'd1;
          3'b100:  ;
          default: protocol_err <= 1'b1;
        endcase
      end else if (timeout_hit) begin
        result_q     <= 3'b100;
        protocol_err <= 1'b1;
      end

      if (state == ST_CHECK) begin
        if (person_score == WIN4) begin
          match_over   <= 1'b1;
          match_winner <= 2'd1;
        end else if (computer_score == WIN4) begin
          match_over   <= 1'b1;
          match_winner <= 2'd2;
        end
      end

      if (state == ST_MATCH_OVER && nm_rise) begin
        person_score   <= '0;
        computer_score <= '0;
        match_over     <= 1'b0;
        match_winner   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rps_match_controller.sv
// Directed bench for rps_match_controller with HOLD_CYCLES=8, WINS_TO_MATCH=2
// (and TIMEOUT_CYCLES=16 when RPS_ROUND_TIMEOUT_EN is defined). Inputs are
// driven 1 time unit after the rising edge, outputs sampled at the same point.
module tb_rps_match_controller;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [2:0] btn_choice = '0;
  logic       new_match = 1'b0;
  logic       round_done = 1'b0;
  logic [2:0] round_result = '0;
  logic       round_start;
  logic [1:0] round_choice;
  logic [2:0] display;
  logic [3:0] person_score, computer_score;
  logic       match_over;
  logic [1:0] match_winner;
  logic       protocol_err;

  int checks = 0;
  int errors = 0;

  rps_match_controller #(
    .WINS_TO_MATCH(2),
    .HOLD_CYCLES(8)
`ifdef RPS_ROUND_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .btn_choice(btn_choice), .new_match(new_match),
    .round_start(round_start), .round_choice(round_choice),
    .round_done(round_done), .round_result(round_result), .display(display),
    .person_score(person_score), .computer_score(computer_score),
    .match_over(match_over), .match_winner(match_winner),
    .protocol_err(protocol_err)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Press, wait for the request, let the judge answer 3 cycles later.
  // Returns right after the edge that consumed round_done (first SHOW cycle).
  task automatic do_round(input logic [2:0] btns, input logic [2:0] res,
                          output logic [1:0] choice);
    int n;
    btn_choice = btns;
    n = 0;
    while (round_start !== 1'b1 && n < 10) begin
      tick(1);
      n++;
    end
    checks++;
    if (round_start !== 1'b1) begin
      errors++;
      $display("FAIL round_request: round_start=%b, required 1 within 10 cycles", round_start);
    end
    choice = round_choice;
    btn_choice = '0;
    tick(2);
    round_done = 1'b1;
    round_result = res;
    tick(1);
    round_done = 1'b0;
    round_result = '0;
  endtask

  task automatic test_reset();
    logic [22:0] got;
    RST_N = 1'b0;
    btn_choice = '0; new_match = 1'b0; round_done = 1'b0; round_result = '0;
    tick(3);
    got = {round_start, round_choice, display, person_score, computer_score,
           match_over, match_winner, protocol_err};
    checks++;
    if (got !== {1'b0, 2'd0, 3'b111, 4'd0, 4'd0, 1'b0, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got %h, required %h", got,
               {1'b0, 2'd0, 3'b111, 4'd0, 4'd0, 1'b0, 2'd0, 1'b0});
    end
    RST_N = 1'b1;
    tick(2);
    checks++;
    if ({round_start, display} !== {1'b0, 3'b111}) begin
      errors++;
      $display("FAIL after_reset: start/display=%b, required 0111", {round_start, display});
    end
  endtask

  task automatic test_rock_round();
    btn_choice = 3'b001;
    tick(3);
    checks++;
    if (round_start !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: round_start=%b at 3 cycles, required 0", round_start);
    end
    tick(1);
    checks++;
    if ({round_start, round_choice} !== {1'b1, 2'd1}) begin
      errors++;
      $display("FAIL latency_4: start/choice=%b, required 101", {round_start, round_choice});
    end
    btn_choice = '0;
    tick(2);
    round_done = 1'b1; round_result = 3'b001;
    tick(1);
    round_done = 1'b0; round_result = '0;
    checks++;
    if ({round_start, person_score, computer_score} !== {1'b0, 4'd1, 4'd0}) begin
      errors++;
      $display("FAIL rock_score: start/p/c=%h, required %h",
               {round_start, person_score, computer_score}, {1'b0, 4'd1, 4'd0});
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (display !== 3'b001) begin
        errors++;
        $display("FAIL rock_show[%0d]: display=%b, required 001", i, display);
      end
      if (i < 7) tick(1);
    end
    tick(1);
    checks++;
    if (display !== 3'b111) begin
      errors++;
      $display("FAIL rock_show_end: display=%b, required 111", display);
    end
    tick(2);
    checks++;
    if ({display, match_over} !== {3'b111, 1'b0}) begin
      errors++;
      $display("FAIL rock_armed: display/match_over=%b, required 1110", {display, match_over});
    end
  endtask

  task automatic test_tie_priority();
    logic [1:0] ch;
    do_round(3'b110, 3'b100, ch);
    checks++;
    if (ch !== 2'd2) begin
      errors++;
      $display("FAIL tie_choice: round_choice=%0d, required 2", ch);
    end
    checks++;
    if ({display, person_score, computer_score} !== {3'b100, 4'd1, 4'd0}) begin
      errors++;
      $display("FAIL tie_result: display/p/c=%h, required %h",
               {display, person_score, computer_score}, {3'b100, 4'd1, 4'd0});
    end
    tick(10);
  endtask

  task automatic test_match_over();
    logic [1:0] ch;
    logic       seen;
    do_round(3'b100, 3'b010, ch);
    checks++;
    if ({ch, computer_score} !== {2'd3, 4'd1}) begin
      errors++;
      $display("FAIL comp_win1: choice/c=%h, required %h", {ch, computer_score}, {2'd3, 4'd1});
    end
    tick(10);
    do_round(3'b001, 3'b010, ch);
    tick(9);
    checks++;
    if ({computer_score, person_score, match_over, match_winner, display} !==
        {4'd2, 4'd1, 1'b1, 2'd2, 3'b010}) begin
      errors++;
      $display("FAIL match_decided: c/p/over/winner/display=%h, required %h",
               {computer_score, person_score, match_over, match_winner, display},
               {4'd2, 4'd1, 1'b1, 2'd2, 3'b010});
    end
    tick(8);
    checks++;
    if (display !== 3'b000) begin
      errors++;
      $display("FAIL blink_off: display=%b, required 000", display);
    end
    tick(8);
    checks++;
    if (display !== 3'b010) begin
      errors++;
      $display("FAIL blink_on: display=%b, required 010", display);
    end
    btn_choice = 3'b001;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (round_start) seen = 1'b1;
    end
    btn_choice = '0;
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL press_in_match_over: round_start seen=%b, required 0", seen);
    end
    tick(4);
    new_match = 1'b1;
    tick(2);
    new_match = 1'b0;
    tick(2);
    checks++;
    if ({person_score, computer_score, match_over, match_winner} !== 11'd0) begin
      errors++;
      $display("FAIL new_match_clear: p/c/over/winner=%h, required 0",
               {person_score, computer_score, match_over, match_winner});
    end
    tick(2);
    checks++;
    if (display !== 3'b111) begin
      errors++;
      $display("FAIL new_match_armed: display=%b, required 111", display);
    end
  endtask

  task automatic test_protocol_err();
    logic [1:0] ch;
    checks++;
    if (protocol_err !== 1'b0) begin
      errors++;
      $display("FAIL err_initial: protocol_err=%b, required 0", protocol_err);
    end
    do_round(3'b001, 3'b011, ch);
    checks++;
    if ({person_score, computer_score, protocol_err} !== {4'd0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL bad_result: p/c/err=%h, required %h",
               {person_score, computer_score, protocol_err}, {4'd0, 4'd0, 1'b1});
    end
    tick(10);
    test_reset();
    round_done = 1'b1;
    tick(1);
    round_done = 1'b0;
    tick(1);
    checks++;
    if ({protocol_err, round_start, person_score, computer_score} !== {1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL stray_done: err/start/p/c=%h, required %h",
               {protocol_err, round_start, person_score, computer_score}, {1'b1, 1'b0, 8'd0});
    end
    tick(5);
    checks++;
    if (protocol_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: protocol_err=%b, required 1", protocol_err);
    end
  endtask

  // Held button: only one round, a fresh press after release gives the next.
  task automatic test_back_to_back();
    int   starts;
    logic rs_prev;
    starts = 0; rs_prev = 1'b0;
    btn_choice = 3'b100;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (round_start && !rs_prev) starts++;
      rs_prev = round_start;
      round_done = round_start;
      round_result = 3'b001;
    end
    round_done = 1'b0;
    checks++;
    if ({starts, person_score} !== {32'd1, 4'd1}) begin
      errors++;
      $display("FAIL held_button: starts=%0d p=%0d, required 1 and 1", starts, person_score);
    end
    btn_choice = '0;
    tick(6);
    starts = 0; rs_prev = 1'b0;
    btn_choice = 3'b100;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (round_start && !rs_prev) starts++;
      rs_prev = round_start;
      round_done = round_start;
      round_result = 3'b001;
    end
    round_done = 1'b0;
    btn_choice = '0;
    checks++;
    if (starts !== 1) begin
      errors++;
      $display("FAIL repress: starts=%0d, required 1", starts);
    end
    tick(12);
    checks++;
    if ({person_score, match_over, match_winner} !== {4'd2, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL person_match: p/over/winner=%h, required %h",
               {person_score, match_over, match_winner}, {4'd2, 1'b1, 2'd1});
    end
  endtask

  task automatic test_async_reset();
    test_reset();
    btn_choice = 3'b001;
    tick(4);
    checks++;
    if (round_start !== 1'b1) begin
      errors++;
      $display("FAIL async_pre: round_start=%b, required 1", round_start);
    end
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if ({round_start, round_choice, display} !== {1'b0, 2'd0, 3'b111}) begin
      errors++;
      $display("FAIL async_reset: start/choice/display=%b, required 000111",
               {round_start, round_choice, display});
    end
    btn_choice = '0;
    tick(2);
    RST_N = 1'b1;
    tick(2);
  endtask

`ifdef RPS_ROUND_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    test_reset();
    btn_choice = 3'b001;
    n = 0;
    while (round_start !== 1'b1 && n < 10) begin
      tick(1);
      n++;
    end
    btn_choice = '0;
    n = 0;
    while (round_start === 1'b1 && n < 40) begin
      n++;
      tick(1);
    end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL timeout_len: round_start high %0d cycles, required 16", n);
    end
    checks++;
    if ({round_start, display, protocol_err, person_score, computer_score} !==
        {1'b0, 3'b100, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL timeout_result: start/display/err/p/c=%h, required %h",
               {round_start, display, protocol_err, person_score, computer_score},
               {1'b0, 3'b100, 1'b1, 8'd0});
    end
    round_done = 1'b1; round_result = 3'b001;
    tick(1);
    round_done = 1'b0; round_result = '0;
    tick(1);
    checks++;
    if ({person_score, computer_score} !== 8'd0) begin
      errors++;
      $display("FAIL late_done: p/c=%h, required 00", {person_score, computer_score});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rock_round();
    test_tie_priority();
    test_match_over();
    test_protocol_err();
    test_back_to_back();
    test_async_reset();
`ifdef RPS_ROUND_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rps_match_controller.md
Name: rps_match_controller

Overview:
- Sequences a first-to-N rock-paper-scissors match around the existing single-round judge datapath on the iCEBreaker.
- Synchronizes and edge-detects the three choice buttons, then issues one round request per press via a start/done handshake.
- Tallies the returned round results, holds each result on the LEDs for a fixed time, and declares the match winner.
- Sits between the board buttons/LEDs and the round judge.

Parameters:
- WINS_TO_MATCH, 3, wins needed to take the match (1..15).
- HOLD_CYCLES, 12000000, CLK cycles each round result stays displayed (1 s at 12 MHz; >=1).
- TIMEOUT_CYCLES, 1024, max cycles waiting for round_done (used only with the optional feature).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- btn_choice  in  3  raw buttons, active-high: bit0 rock, bit1 paper, bit2 scissors.
- new_match  in  1  raw button, active-high: clears scores after match over.
- round_start  out  1  round request to judge.
- round_choice  out  2  person choice to judge: 1 rock, 2 paper, 3 scissors.
- round_done  in  1  judge completion strobe.
- round_result  in  3  judge result, one-hot: 1 person wins, 2 computer wins, 4 tie.
- display  out  3  LED pattern {LED1,LED2,LED3}.
- person_score  out  4  person round wins.
- computer_score  out  4  computer round wins.
- match_over  out  1  high while match is decided.
- match_winner  out  2  0 none, 1 person, 2 computer.
- protocol_err  out  1  sticky error flag.

Behaviour:
- Reset: state ARMED, round_start=0, round_choice=0, display=3'b111, both scores 0, match_over=0, match_winner=0, protocol_err=0, synchronizer flops 0.
- Inputs: btn_choice and new_match each pass a 2-flop synchronizer. A press is a rising edge of the synchronized OR of btn_choice.
- Simultaneous buttons: lowest index wins (rock > paper > scissors).
- ARMED: display=3'b111. On a press, latch round_choice and go to REQUEST on the next cycle. Press-to-round_start latency is 4 cycles from the raw edge.
- REQUEST: round_start=1 with round_choice held stable. round_done is sampled only here.
  - When round_done=1: latch round_result, drop round_start the next cycle, go to SHOW.
  - Any round_done outside REQUEST is ignored and sets protocol_err.
- Result decode:
  - 1: person_score+1. 2: computer_score+1. 4: no change.
  - Any other value is treated as a tie and sets protocol_err.
  - Scores never exceed WINS_TO_MATCH.
- SHOW: display=latched result. Hold counter runs HOLD_CYCLES cycles. Button presses during SHOW are discarded. Then go to CHECK.
- CHECK (1 cycle):
  - If either score == WINS_TO_MATCH: set match_over=1 and match_winner, go to MATCH_OVER.
  - Otherwise go to RELEASE.
- RELEASE: wait until all synchronized btn_choice bits are 0, then ARMED. This blocks auto-repeat from a held button.
- MATCH_OVER: display toggles between the winner code (1 or 2) and 3'b000 every HOLD_CYCLES cycles; choice buttons are ignored. A rising edge of synchronized new_match clears scores, match_over and match_winner, then goes to RELEASE.
- protocol_err is cleared only by reset.
- Reset asserted mid-operation forces the reset values immediately; round_start drops asynchronously.

Optional Feature:
- Macro: RPS_ROUND_TIMEOUT_EN.
- Defined: a counter runs in REQUEST. If round_done is not seen within TIMEOUT_CYCLES cycles, round_start drops, the round is scored as a tie (display 3'b100), protocol_err is set, and the state moves to SHOW. A round_done arriving after the timeout is ignored.
- Undefined: REQUEST waits indefinitely and the timeout counter is absent.

Test Plan:
- Bench uses HOLD_CYCLES=8, WINS_TO_MATCH=2.
- Reset, then press rock; judge returns 1 after 3 cycles -> round_start high 4 cycles after the edge, round_choice=1; person_score=1; display=3'b001 for 8 cycles, then 3'b111 after release.
- Press paper+scissors together; judge returns 4 -> round_choice=2; scores unchanged; display=3'b100.
- Two computer wins (result 2, 2) -> computer_score=2, match_over=1, match_winner=2, display blinks 3'b010/3'b000; a further rock press produces no round_start; new_match pulse -> scores 0, match_over=0.
- Judge returns 3'b011, and a stray round_done is driven in ARMED -> counted as a tie; protocol_err=1 and stays set.
- Hold scissors through SHOW -> exactly one round_start; the next round starts only after release and a new press.
- With RPS_ROUND_TIMEOUT_EN, TIMEOUT_CYCLES=16, no round_done -> round_start drops after 16 cycles, display=3'b100, protocol_err=1.
